// File: rtl/apb_vgachargen_bridge.sv
// apb_vgachargen_bridge
// APB3 slave giving word-mapped CPU access to the text-mode VGA memories in
// vgachargen_wrapper: character map, colour map and the 128-bit glyph table.
// 32-bit glyph-slice writes are merged into a full 128-bit row by
// read-modify-write.
//
// Optional feature macro: APB_VGACHARGEN_READBACK_EN
//   defined     : reads return memory data after one wait state and glyph
//                 writes merge with the current row contents.
//   not defined : valid reads finish with no wait state and return 0, and
//                 glyph writes zero the slices that are not being written.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   psel_i, penable_i, pwrite_i  APB control
//   paddr_i, pwdata_i            APB byte address and write data
//   prdata_o, pready_o, pslverr_o APB response
//   ch_map_*                     character-map addr/data/wen out, read data in
//   col_map_*                    colour-map addr/data/wen out, read data in
//   ch_t_rw_*                    glyph-table addr/data/wen out, read data in
module apb_vgachargen_bridge #(
    parameter int unsigned DEC_W     = 16,
    parameter int unsigned MAP_DEPTH = 2400,
    parameter int unsigned GLYPHS    = 128
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         psel_i,
    input  logic         penable_i,
    input  logic         pwrite_i,
    input  logic [31:0]  paddr_i,
    input  logic [31:0]  pwdata_i,
    output logic [31:0]  prdata_o,
    output logic         pready_o,
    output logic         pslverr_o,
    output logic [11:0]  ch_map_addr_o,
    output logic [7:0]   ch_map_data_o,
    output logic         ch_map_wen_o,
    input  logic [7:0]   ch_map_data_i,
    output logic [11:0]  col_map_addr_o,
    output logic [7:0]   col_map_data_o,
    output logic         col_map_wen_o,
    input  logic [7:0]   col_map_data_i,
    output logic [6:0]   ch_t_rw_addr_o,
    output logic [127:0] ch_t_rw_data_o,
    output logic         ch_t_rw_wen_o,
    input  logic [127:0] ch_t_rw_data_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    localparam logic [1:0] RegCh    = 2'd0;
    localparam logic [1:0] RegCol   = 2'd1;
    localparam logic [1:0] RegGlyph = 2'd2;
    localparam logic [1:0] RegErr   = 2'd3;

    // Bits at or above DEC_W are ignored by masking them off.
    localparam logic [31:0] ADDR_MASK =
        (DEC_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DEC_W) - 32'd1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  region_q, region_d;
    logic [11:0] idx_q;
    logic [6:0]  row_q;
    logic [1:0]  slice_q;
    logic        write_q;
    logic [31:0] wdata_q;

    logic [31:0] dec_addr;
    logic [11:0] dec_map_idx;
    logic [9:0]  dec_row_idx;
    logic        setup;

    assign dec_addr    = paddr_i & ADDR_MASK;
    assign dec_map_idx = dec_addr[13:2];
    assign dec_row_idx = dec_addr[13:4];
    assign setup       = (state_q == StIdle) && psel_i && !penable_i;

    // Address decode; anything not explicitly mapped is an error.
    always_comb begin
        region_d = RegErr;
        if (dec_addr[1:0] == 2'b00 && dec_addr[31:16] == 16'd0) begin
            case (dec_addr[15:14])
                2'b00: if ({20'd0, dec_map_idx} < MAP_DEPTH) region_d = RegCh;
                2'b01: if ({20'd0, dec_map_idx} < MAP_DEPTH) region_d = RegCol;
                2'b10: if ({22'd0, dec_row_idx} < GLYPHS)    region_d = RegGlyph;
                default: region_d = RegErr;
            endcase
        end
    end

    // Glyph row merge: without readback the untouched slices are written as 0.
    logic [127:0] merge_base;
    logic [127:0] merged;
`ifdef APB_VGACHARGEN_READBACK_EN
    assign merge_base = ch_t_rw_data_i;
`else
    assign merge_base = '0;
    logic unused_rd;
    assign unused_rd = ^{ch_map_data_i, col_map_data_i, ch_t_rw_data_i};
`endif

    always_comb begin
        merged = merge_base;
        merged[{slice_q, 5'd0} +: 32] = wdata_q;
    end

    always_comb begin
        state_d        = state_q;
        prdata_o       = '0;
        pready_o       = 1'b0;
        pslverr_o      = 1'b0;
        ch_map_wen_o   = 1'b0;
        col_map_wen_o  = 1'b0;
        ch_t_rw_wen_o  = 1'b0;
        ch_t_rw_data_o = '0;
        case (state_q)
            StIdle: begin
                if (setup) state_d = StAcc;
            end
            StAcc: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (region_q == RegErr) begin
                    pready_o  = 1'b1;
                    pslverr_o = 1'b1;
                    state_d   = StIdle;
                end else if (write_q && region_q != RegGlyph) begin
                    pready_o      = 1'b1;
                    ch_map_wen_o  = (region_q == RegCh);
                    col_map_wen_o = (region_q == RegCol);
                    state_d       = StIdle;
                end else if (write_q) begin
                    state_d = StWait;
                end else begin
`ifdef APB_VGACHARGEN_READBACK_EN
                    state_d = StWait;
`else
                    pready_o = 1'b1;
                    state_d  = StIdle;
`endif
                end
            end
            StWait: begin
                state_d = StIdle;
                if (psel_i) begin
                    pready_o = 1'b1;
                    if (write_q) begin
                        ch_t_rw_wen_o  = 1'b1;
                        ch_t_rw_data_o = merged;
                    end else begin
                        case (region_q)
                            RegCh:    prdata_o = {24'd0, ch_map_data_i};
                            RegCol:   prdata_o = {24'd0, col_map_data_i};
                            RegGlyph: prdata_o = ch_t_rw_data_i[{slice_q, 5'd0} +: 32];
                            default:  prdata_o = '0;
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            region_q <= RegCh;
            idx_q    <= '0;
            row_q    <= '0;
            slice_q  <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                region_q <= region_d;
                idx_q    <= dec_map_idx;
                row_q    <= dec_row_idx[6:0];
                slice_q  <= dec_addr[3:2];
                write_q  <= pwrite_i;
                wdata_q  <= pwdata_i;
            end
        end
    end

    // Addresses and map write data come straight from the latched registers.
    assign ch_map_addr_o  = idx_q;
    assign col_map_addr_o = idx_q;
    assign ch_t_rw_addr_o = row_q;
    assign ch_map_data_o  = wdata_q[7:0];
    assign col_map_data_o = wdata_q[7:0];

endmodule

// File: doc/apb_vgachargen_bridge.md
# apb_vgachargen_bridge

APB3 slave that gives the CPU word-mapped access to the three text-mode VGA memories (character map, colour map, 128-bit glyph table). Sits directly upstream of `vgachargen_wrapper`: its memory-side outputs drive the wrapper's `ch_map_*`, `col_map_*` and `ch_t_rw_*` inputs, and its memory-side inputs take the wrapper's read-data outputs. It also merges 32-bit glyph-slice writes into 128-bit glyph rows by read-modify-write.

## Interface
Parameters:
- DEC_W, 16, number of low `paddr_i` bits decoded; upper bits ignored.
- MAP_DEPTH, 2400, character and colour map entries (80×30).
- GLYPHS, 128, glyph-table rows.

Ports (one clock; reset asynchronous, active-high):
- clk_i  in  1  system clock, same clock as the wrapper.
- rst_i  in  1  asynchronous active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- paddr_i  in  32  byte address.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response.
- ch_map_addr_o  out  12  character-map index.
- ch_map_data_o  out  8  character-map write data.
- ch_map_wen_o  out  1  character-map write strobe.
- ch_map_data_i  in  8  character-map read data.
- col_map_addr_o  out  12  colour-map index.
- col_map_data_o  out  8  colour-map write data.
- col_map_wen_o  out  1  colour-map write strobe.
- col_map_data_i  in  8  colour-map read data.
- ch_t_rw_addr_o  out  7  glyph-table row index.
- ch_t_rw_data_o  out  128  glyph-table write data.
- ch_t_rw_wen_o  out  1  glyph-table write strobe.
- ch_t_rw_data_i  in  128  glyph-table read data.

## Operation
Address map, taken from `paddr_i[DEC_W-1:0]`:
- 0x0000 + 4·i, i < MAP_DEPTH: character map. Data is in bits [7:0].
- 0x4000 + 4·i, i < MAP_DEPTH: colour map. Data is in bits [7:0].
- 0x8000 + 16·g + 4·w, g < GLYPHS, w < 4: glyph row g, bits [32w+31:32w].
- Decode errors: any other address, an index ≥ MAP_DEPTH, or `paddr_i[1:0]` ≠ 0. The transfer completes with `pslverr_o` = 1. Writes have no effect and `prdata_o` = 0.

State machine states are IDLE, ACC and WAIT.
- IDLE: in the setup phase (`psel_i` & ~`penable_i`), latch the decoded region, index, slice, `pwrite_i` and `pwdata_i`. Go to ACC.
- ACC, map write: assert the map `wen` for one cycle with the latched addr/data. `pready_o` = 1. Go to IDLE.
- ACC, error: `pready_o` = 1, `pslverr_o` = 1. Go to IDLE.
- ACC, any read or glyph write: the memory address is presented. `pready_o` = 0. Go to WAIT.
- WAIT, read: `prdata_o` = zero-extended map byte, or the selected 32-bit glyph slice. `pready_o` = 1. Go to IDLE.
- WAIT, glyph write: `ch_t_rw_data_o` = `ch_t_rw_data_i` with slice w replaced by the latched `pwdata_i`. `ch_t_rw_wen_o` = 1 and `pready_o` = 1. Go to IDLE.
- `psel_i` deasserted while in ACC or WAIT (protocol violation): abort to IDLE. No `wen` is asserted.
- Memory address outputs are driven from the latched registers and hold their value between transfers.
- `prdata_o` is 0 whenever `pready_o` = 0.

## Timing
- Reset values: state = IDLE; all latched registers = 0; `pready_o`, `pslverr_o`, every `*_wen_o` = 0; `prdata_o` = 0; all addr/data outputs = 0.
- Memory read latency is 1 cycle: read data is valid the cycle after the address is presented.
- Wait states: map write = 0; error = 0; map read = 1; glyph read = 1; glyph write = 1 (read-modify-write).
- Each `wen` is a single-cycle pulse, coincident with `pready_o`.
- Back-to-back transfers: the next setup phase can start the cycle after `pready_o`. A write followed immediately by a read to the same entry returns the new value.
- Reset asserted mid-transfer: everything clears immediately (asynchronously). No partial glyph write occurs.

## Configuration
- `APB_VGACHARGEN_READBACK_EN` defined: reads behave as described above.
- Not defined:
  - Reads to valid addresses complete in ACC with 0 wait states and `prdata_o` = 0.
  - Glyph writes skip the merge: the written slice gets `pwdata_i`, the other slices are written as 0. They still take 1 wait state.
  - Writes and error responses are unchanged.

## Test plan
- Write 0x41 to 0x0000_0010: `ch_map_wen_o` pulses with addr = 4 and data = 0x41. `pready_o` = 1 in the first access cycle, `pslverr_o` = 0.
- Write 0x1F to colour index 2399 (0x4000 + 9596), then read it back: readback = 0x0000_001F after 1 wait state.
- Glyph RMW: preload row 5 = 0x…FFFF (all ones), then write 0x1234_5678 to 0x8000 + 80 + 8. `ch_t_rw_data_o` = all ones except bits [95:64] = 0x1234_5678, `wen` = 1 for one cycle.
- Errors: access to 0x2580 (index 2400) and to 0x0001 → `pslverr_o` = 1, no `wen`, `prdata_o` = 0, 0 wait states.
- Reset mid glyph write: assert `rst_i` during ACC → `pready_o` and `ch_t_rw_wen_o` = 0 immediately, state returns to IDLE, memory contents unchanged.
- Build without `APB_VGACHARGEN_READBACK_EN`: a read of any valid address returns 0 with 0 wait states.
